// File: rtl/wh_output_arbiter.sv
// Wormhole output-port arbiter: round-robin selection among head flits, then holds the
// output for the winning input until its tail flit passes. Counts completed packets and
// flags a head flit that arrives on an input already holding the output.
module wh_output_arbiter #(
  parameter int N_OF_INPUTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_OF_INPUTS-1:0] req_i,
  input  logic [N_OF_INPUTS-1:0] head_i,
  input  logic [N_OF_INPUTS-1:0] tail_i,
  input  logic                   out_ready_i,
  output logic [N_OF_INPUTS-1:0] grant_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic [15:0]            pkt_cnt_o,
  output logic                   err_o
);

  localparam int PW = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic          state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] lock_q, lock_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          err_q, err_d;

  logic [N_OF_INPUTS-1:0] eligible;
  logic [PW-1:0]          winner;
  logic                   found;
  logic                   transfer;

  // Round-robin search for the first head-flit request at or above rr_ptr, wrapping to 0.
  always_comb begin
    int            start;
    int            idx;
    logic [PW-1:0] cand;
    eligible = req_i & head_i;
    winner   = '0;
    found    = 1'b0;
    start    = (int'(rr_ptr_q) >= N_OF_INPUTS) ? 0 : int'(rr_ptr_q);
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < N_OF_INPUTS; k++) begin
      idx = start + k;
      if (idx >= N_OF_INPUTS) idx = idx - N_OF_INPUTS;
      cand = PW'(idx);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant: locked input while a packet is open, else the round-robin winner; none in reset.
  always_comb begin
    grant_o = '0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        grant_o[lock_q] = 1'b1;
      end else if (found) begin
        grant_o[winner] = 1'b1;
      end
    end
  end

  assign out_valid_o = |(grant_o & req_i);
  assign transfer    = out_valid_o & out_ready_i;
  assign busy_o      = (state_q == ST_LOCKED);
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_o       = err_q;

  // Next-state: advance pointer / open lock on a head transfer, close lock on a tail.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    if (state_q == ST_IDLE) begin
      if (transfer) begin
        rr_ptr_d = (int'(winner) == N_OF_INPUTS - 1) ? '0 : winner + 1'b1;
        if (tail_i[winner]) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
          lock_d  = winner;
          state_d = ST_LOCKED;
        end
      end
    end else begin
      if (transfer) begin
        // A head on the locked input means the previous packet lost its tail.
        if (head_i[lock_q]) err_d = 1'b1;
        if (tail_i[lock_q]) begin
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_wh_output_arbiter.sv
// Scoreboard bench for wh_output_arbiter (4 inputs): stimulus queues the expected grant of
// every cycle that should transfer a flit; a negedge monitor pops and compares on transfers.
module tb_wh_output_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, head, tail;
  logic        rdy;
  logic [3:0]  grant;
  logic        out_valid, busy, err;
  logic [15:0] pkt_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  wh_output_arbiter #(.N_OF_INPUTS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .head_i      (head),
    .tail_i      (tail),
    .out_ready_i (rdy),
    .grant_o     (grant),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .pkt_cnt_o   (pkt_cnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the rising edge, queue the expected grant if a transfer is
  // expected (eg != 0), then stop at the falling edge for direct checks.
  task automatic cyc(input logic rs, input logic [3:0] r, input logic [3:0] h,
                     input logic [3:0] t, input logic rd, input logic [3:0] eg);
    @(posedge clk);
    #1;
    rst  = rs;
    req  = r;
    head = h;
    tail = t;
    rdy  = rd;
    if (eg != 4'b0000) exp_q.push_back(eg);
    @(negedge clk);
  endtask

  // Monitor: every transfer must match the next queued grant.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst === 1'b0) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got grant %b expected no transfer at %0t", grant, $time);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_grant", 32'(grant), 32'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'b1111; head = 4'b1111; tail = 4'b1111; rdy = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    // Reset state, grant forced off while rst is high.
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Two single-flit packets, inputs 0 then 2.
    cyc(0, 4'b0101, 4'b0101, 4'b0101, 1, 4'b0001);
    chk("t1_busy", 32'(busy), 32'd0);
    cyc(0, 4'b0101, 4'b0101, 4'b0101, 1, 4'b0100);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t1_cnt", 32'(pkt_cnt), 32'd2);
    // rr_ptr is 3, so input 3 beats input 0.
    cyc(0, 4'b1001, 4'b1001, 4'b1001, 1, 4'b1000);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t1_cnt3", 32'(pkt_cnt), 32'd3);

    // 3-flit packet on input 1 while 0 and 2 offer heads.
    cyc(0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001);
    cyc(0, 4'b0111, 4'b0111, 4'b0101, 1, 4'b0010);
    chk("t2_busy_h", 32'(busy), 32'd0);
    cyc(0, 4'b0111, 4'b0101, 4'b0101, 1, 4'b0010);
    chk("t2_busy_b", 32'(busy), 32'd1);
    cyc(0, 4'b0111, 4'b0101, 4'b0111, 1, 4'b0010);
    chk("t2_busy_t", 32'(busy), 32'd1);
    cyc(0, 4'b0101, 4'b0101, 4'b0101, 1, 4'b0100);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_cnt", 32'(pkt_cnt), 32'd5);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t2_cnt6", 32'(pkt_cnt), 32'd6);

    // Lock on input 2, back-pressure then source stall.
    cyc(0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100);
    repeat (5) begin
      cyc(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000);
      chk("t3_hold_grant", 32'(grant), 32'b0100);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_busy", 32'(busy), 32'd1);
    end
    repeat (3) begin
      cyc(0, 4'b1011, 4'b1011, 4'b0000, 1, 4'b0000);
      chk("t3_stall_grant", 32'(grant), 32'b0100);
      chk("t3_stall_valid", 32'(out_valid), 32'd0);
      chk("t3_stall_busy", 32'(busy), 32'd1);
    end
    cyc(0, 4'b0100, 4'b0000, 4'b0100, 1, 4'b0100);
    chk("t3_tail_busy", 32'(busy), 32'd1);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_cnt", 32'(pkt_cnt), 32'd7);

    // Head flit on locked input 3 before its tail.
    cyc(0, 4'b1000, 4'b1000, 4'b0000, 1, 4'b1000);
    cyc(0, 4'b1000, 4'b1000, 4'b0000, 1, 4'b1000);
    chk("t4_err_pre", 32'(err), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    cyc(0, 4'b1000, 4'b0000, 4'b1000, 1, 4'b1000);
    chk("t4_err_set", 32'(err), 32'd1);
    chk("t4_cnt_hold", 32'(pkt_cnt), 32'd7);
    chk("t4_busy2", 32'(busy), 32'd1);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_cnt", 32'(pkt_cnt), 32'd8);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // Reset mid-packet with pkt_cnt = 5.
    cyc(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    repeat (5) cyc(0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001);
    chk("t5_err_clr", 32'(err), 32'd0);
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010);
    chk("t5_cnt5", 32'(pkt_cnt), 32'd5);
    cyc(1, 4'b0010, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy_pre", 32'(busy), 32'd1);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnt", 32'(pkt_cnt), 32'd0);
    // Arbitration restarts from index 0.
    cyc(0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0001);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t5_cnt1", 32'(pkt_cnt), 32'd1);

    // Counter wrap.
    cyc(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    repeat (65535) cyc(0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001);
    cyc(0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001);
    chk("t6_cnt_max", 32'(pkt_cnt), 32'hFFFF);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("t6_cnt_wrap", 32'(pkt_cnt), 32'h0000);
    chk("t6_err", 32'(err), 32'd0);

    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
